// File: rtl/board_regs_gen.sv
// board_regs_gen: channel-0 (board-level) register file for FPGA1394 motor-controller boards.
//
// Parameters:
//   NUM_CH          number of amplifier channels (1..8)
//   WDOG_DIV_WIDTH  watchdog prescaler width; one tick every 2^WDOG_DIV_WIDTH sysclk cycles
//   VERSION         hard-wired board version word (address 4)
//   FW_VERSION      firmware version word (address 7)
//
// Ports:
//   sysclk        system clock
//   reset         synchronous, active-low reset
//   reg_addr      register address; board space when reg_addr[7:4] == 0
//   reg_wdata     write data
//   wr_en         single-cycle write strobe (any address also kicks the watchdog)
//   reg_rdata     registered read data, one cycle after the address is presented
//   fault         amplifier fault inputs, active-high
//   neg_limit     negative limit switch inputs
//   pos_limit     positive limit switch inputs
//   home          home switch inputs
//   board_id      rotary switch board ID
//   amp_disable   amplifier disables, 1 = disabled
//   dout          digital outputs
//   relay_on      safety relay enable
//   pwr_enable    motor power enable
//   wdog_timeout  watchdog expired flag
module board_regs_gen #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WDOG_DIV_WIDTH = 8,
  parameter logic [31:0] VERSION        = 32'h514C4131,
  parameter logic [31:0] FW_VERSION     = 32'h02
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  input  logic              wr_en,
  output logic [31:0]       reg_rdata,
  input  logic [NUM_CH-1:0] fault,
  input  logic [NUM_CH-1:0] neg_limit,
  input  logic [NUM_CH-1:0] pos_limit,
  input  logic [NUM_CH-1:0] home,
  input  logic [3:0]        board_id,
  output logic [NUM_CH-1:0] amp_disable,
  output logic [NUM_CH-1:0] dout,
  output logic              relay_on,
  output logic              pwr_enable,
  output logic              wdog_timeout
);

  localparam logic [3:0] AddrStatus  = 4'd0;
  localparam logic [3:0] AddrTimeout = 4'd3;
  localparam logic [3:0] AddrVersion = 4'd4;
  localparam logic [3:0] AddrDigiout = 4'd6;
  localparam logic [3:0] AddrFwVer   = 4'd7;
  localparam logic [3:0] AddrDigiin  = 4'd10;
  localparam logic [3:0] AddrFault   = 4'd11;

  logic [NUM_CH-1:0]         dis_q, dis_d;
  logic [NUM_CH-1:0]         fault_latch_q, fault_latch_d;
  logic [NUM_CH-1:0]         dout_q, dout_d;
  logic                      relay_q, relay_d;
  logic                      pwr_q, pwr_d;
  logic                      wdog_q, wdog_d;
  logic [15:0]               period_q, period_d;
  logic [15:0]               count_q, count_d;
  logic [WDOG_DIV_WIDTH-1:0] presc_q, presc_d;
  logic [31:0]               rdata_q, rdata_d;

  logic        board_wr;
  logic        wr_status, wr_timeout, wr_digiout, wr_fault;
  logic        tick;
  logic        wdog_rise;
  logic [7:0]  dis_n8;
  logic [7:0]  latch8;
  logic [31:0] rd_map;

  assign board_wr   = wr_en && (reg_addr[7:4] == 4'd0);
  assign wr_status  = board_wr && (reg_addr[3:0] == AddrStatus);
  assign wr_timeout = board_wr && (reg_addr[3:0] == AddrTimeout);
  assign wr_digiout = board_wr && (reg_addr[3:0] == AddrDigiout);
  assign wr_fault   = board_wr && (reg_addr[3:0] == AddrFault);

  assign tick = &presc_q;

  // Watchdog: any write kicks it; a kick in the same cycle as a tick wins.
  always_comb begin
    presc_d  = presc_q + 1'b1;
    period_d = period_q;
    count_d  = count_q;
    wdog_d   = wdog_q;
    if (wr_timeout) begin
      period_d = reg_wdata[15:0];
    end
    if (wr_en) begin
      count_d = 16'd0;
      wdog_d  = 1'b0;
    end else if (period_q == 16'd0) begin
      count_d = 16'd0;
    end else if (tick) begin
      // count saturates at period; reaching a tick while saturated expires the watchdog
      if (count_q < period_q) begin
        count_d = count_q + 16'd1;
      end else begin
        wdog_d = 1'b1;
      end
    end
  end

  assign wdog_rise = wdog_d & ~wdog_q;

  // Channel enables and fault latches: a live fault (or a watchdog expiry) beats a host write.
  always_comb begin
    dis_d         = dis_q;
    fault_latch_d = fault_latch_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_status && reg_wdata[8+i]) begin
        dis_d[i] = ~reg_wdata[i];
      end
      if (wr_fault && reg_wdata[i]) begin
        fault_latch_d[i] = 1'b0;
      end
      if (fault[i]) begin
        dis_d[i]         = 1'b1;
        fault_latch_d[i] = 1'b1;
      end
      if (wdog_rise) begin
        dis_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    relay_d = wr_status ? reg_wdata[16] : relay_q;
    pwr_d   = wr_status ? reg_wdata[17] : pwr_q;
    dout_d  = wr_digiout ? reg_wdata[NUM_CH-1:0] : dout_q;
  end

  // Read map, zero-extending per-channel fields to their 8-bit slots.
  always_comb begin
    dis_n8                = 8'd0;
    dis_n8[NUM_CH-1:0]    = ~dis_q;
    latch8                = 8'd0;
    latch8[NUM_CH-1:0]    = fault_latch_q;
    rd_map                = 32'd0;
    case (reg_addr[3:0])
      AddrStatus:  rd_map = {6'd0, pwr_q, relay_q, board_id, wdog_q, 3'd0, latch8, dis_n8};
      AddrTimeout: rd_map = {16'd0, period_q};
      AddrVersion: rd_map = VERSION;
      AddrDigiout: rd_map[NUM_CH-1:0] = dout_q;
      AddrFwVer:   rd_map = FW_VERSION;
      AddrDigiin:  rd_map[3*NUM_CH-1:0] = {home, pos_limit, neg_limit};
      AddrFault:   rd_map[NUM_CH-1:0] = fault_latch_q;
      default:     rd_map = 32'd0;
    endcase
    // read data is frozen while the bus is writing board registers
    rdata_d = board_wr ? rdata_q : rd_map;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      dis_q         <= '1;
      fault_latch_q <= '0;
      dout_q        <= '0;
      relay_q       <= 1'b0;
      pwr_q         <= 1'b0;
      wdog_q        <= 1'b0;
      period_q      <= 16'd0;
      count_q       <= 16'd0;
      presc_q       <= '0;
      rdata_q       <= 32'd0;
    end else begin
      dis_q         <= dis_d;
      fault_latch_q <= fault_latch_d;
      dout_q        <= dout_d;
      relay_q       <= relay_d;
      pwr_q         <= pwr_d;
      wdog_q        <= wdog_d;
      period_q      <= period_d;
      count_q       <= count_d;
      presc_q       <= presc_d;
      rdata_q       <= rdata_d;
    end
  end

  assign reg_rdata    = rdata_q;
  assign amp_disable  = dis_q | {NUM_CH{wdog_q}};
  assign dout         = dout_q;
  assign relay_on     = relay_q;
  assign pwr_enable   = pwr_q;
  assign wdog_timeout = wdog_q;

endmodule

// File: tb/tb_board_regs_gen.sv
// tb_board_regs_gen: scoreboard bench for board_regs_gen (NUM_CH=4, WDOG_DIV_WIDTH=2).
// Stimulus pushes expected values tagged with the cycle they apply to; a negedge monitor
// pops and compares them against reg_rdata or a packed view of the output pins.
module tb_board_regs_gen;

  localparam logic [31:0] Version = 32'h514C4131;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        wr_en;
  logic [31:0] reg_rdata;
  logic [3:0]  fault, neg_limit, pos_limit, home, board_id;
  logic [3:0]  amp_disable, dout;
  logic        relay_on, pwr_enable, wdog_timeout;

  board_regs_gen #(
    .NUM_CH        (4),
    .WDOG_DIV_WIDTH(2),
    .VERSION       (Version),
    .FW_VERSION    (32'h02)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .wr_en       (wr_en),
    .reg_rdata   (reg_rdata),
    .fault       (fault),
    .neg_limit   (neg_limit),
    .pos_limit   (pos_limit),
    .home        (home),
    .board_id    (board_id),
    .amp_disable (amp_disable),
    .dout        (dout),
    .relay_on    (relay_on),
    .pwr_enable  (pwr_enable),
    .wdog_timeout(wdog_timeout)
  );

  always #5 sysclk = ~sysclk;

  // cyc counts every edge; rel counts edges since reset release (prescaler phase model)
  int unsigned cyc = 0;
  int unsigned rel = 0;
  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (reset) rel <= rel + 1;
  end

  // pins: bit10 wdog_timeout, bit9 pwr_enable, bit8 relay_on, [7:4] dout, [3:0] amp_disable
  logic [31:0] pins;
  assign pins = {21'd0, wdog_timeout, pwr_enable, relay_on, dout, amp_disable};

  int unsigned due_q[$];
  bit          kind_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          drain = 1'b0;

  always @(negedge sysclk) begin : monitor
    int unsigned d;
    bit          k;
    logic [31:0] e, m, act;
    string       n;
    while (due_q.size() > 0 && (drain || due_q[0] <= cyc)) begin
      d   = due_q.pop_front();
      k   = kind_q.pop_front();
      e   = exp_q.pop_front();
      m   = mask_q.pop_front();
      n   = name_q.pop_front();
      act = k ? pins : reg_rdata;
      checks++;
      if (d != cyc) begin
        errors++;
        $display("FAIL %s: not sampled on cycle %0d (now %0d)", n, d, cyc);
      end else if ((act & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (mask %h)", n, act & m, e & m, m);
      end
    end
  end

  task automatic push(input bit kind, input int unsigned due, input logic [31:0] exp,
                      input logic [31:0] mask, input string name);
    due_q.push_back(due);
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
    name_q.push_back(name);
  endtask

  task automatic cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    wr_en     = 1'b1;
    cycle();
    wr_en     = 1'b0;
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [31:0] exp, input string name);
    reg_addr = a;
    wr_en    = 1'b0;
    push(1'b0, cyc + 1, exp, 32'hFFFF_FFFF, name);
    cycle();
  endtask

  task automatic pin_expect(input logic [31:0] exp, input logic [31:0] mask, input string name);
    push(1'b1, cyc, exp, mask, name);
  endtask

  initial begin
    reset     = 1'b0;
    reg_addr  = 8'd0;
    reg_wdata = 32'd0;
    wr_en     = 1'b0;
    fault     = 4'd0;
    neg_limit = 4'h3;
    pos_limit = 4'h5;
    home      = 4'hA;
    board_id  = 4'h9;

    cycles(2);
    pin_expect(32'h0000_000F, 32'h0000_07FF, "reset_pins");
    push(1'b0, cyc, 32'd0, 32'hFFFF_FFFF, "reset_rdata");
    reset = 1'b1;
    cycle();

    rd_expect(8'd4, Version, "rd_version");
    rd_expect(8'd7, 32'h0000_0002, "rd_fw_version");
    rd_expect(8'd10, 32'h0000_0A53, "rd_digiin");

    // enable ch0/ch1, relay and power
    wr(8'd0, 32'h0003_0303);
    pin_expect(32'h0000_030C, 32'h0000_070F, "status_wr_pins");
    rd_expect(8'd0, 32'h0390_0003, "rd_status");

    // enable ch2, then a one-cycle fault on it
    wr(8'd0, 32'h0003_0404);
    pin_expect(32'h0000_0308, 32'h0000_030F, "ch2_enable");
    fault = 4'b0100;
    cycle();
    fault = 4'b0000;
    pin_expect(32'h0000_030C, 32'h0000_030F, "fault2_disables");
    rd_expect(8'd11, 32'h0000_0004, "fault2_latched");
    rd_expect(8'd0, 32'h0390_0403, "status_with_fault");
    wr(8'd11, 32'h0000_0004);
    rd_expect(8'd11, 32'h0000_0000, "w1c_clears");
    fault = 4'b0100;
    cycle();
    wr(8'd11, 32'h0000_0004);
    rd_expect(8'd11, 32'h0000_0004, "w1c_fault_held");
    fault = 4'b0000;
    wr(8'd11, 32'h0000_0004);
    rd_expect(8'd11, 32'h0000_0000, "w1c_after_release");

    // enable write and fault on ch1 in the same cycle: fault wins
    fault = 4'b0010;
    wr(8'd0, 32'h0003_0202);
    fault = 4'b0000;
    pin_expect(32'h0000_030E, 32'h0000_030F, "fault_beats_enable");
    wr(8'd11, 32'h0000_0002);
    rd_expect(8'd11, 32'h0000_0000, "w1c_ch1");

    wr(8'd6, 32'hFFFF_FFF5);
    pin_expect(32'h0000_0050, 32'h0000_00F0, "dout_wr");
    rd_expect(8'd6, 32'h0000_0005, "rd_dout");

    // watchdog: period 3 -> expires on the 4th tick after the write (edges +13..+16)
    wr(8'd0, 32'h0003_0F0F);
    pin_expect(32'h0000_0300, 32'h0000_070F, "all_enabled");
    wr(8'd3, 32'h0000_0003);
    cycles(12);
    pin_expect(32'h0000_0000, 32'h0000_040F, "wdog_not_yet");
    cycles(4);
    pin_expect(32'h0000_040F, 32'h0000_040F, "wdog_expired");
    rd_expect(8'd0, 32'h0398_0000, "status_wdog");
    rd_expect(8'd3, 32'h0000_0003, "rd_period");
    wr(8'd6, 32'h0000_0005);
    pin_expect(32'h0000_005F, 32'h0000_04FF, "kick_keeps_disabled");

    // align a kick onto a tick edge; ticks land on released edges that are multiples of 4
    while (((rel + 1) % 4) != 0) cycle();
    wr(8'd6, 32'h0000_0005);
    cycles(15);
    pin_expect(32'h0000_0000, 32'h0000_0400, "count_at_period");
    wr(8'd6, 32'h0000_0005);
    pin_expect(32'h0000_0000, 32'h0000_0400, "kick_beats_tick");
    cycles(15);
    pin_expect(32'h0000_0000, 32'h0000_0400, "wdog_edge_minus1");
    cycles(2);
    pin_expect(32'h0000_0400, 32'h0000_0400, "wdog_reexpired");

    // period 0 disables the watchdog
    wr(8'd3, 32'h0000_0000);
    pin_expect(32'h0000_000F, 32'h0000_040F, "period0_kick");
    for (int i = 0; i < 4; i++) begin
      cycles(500);
      pin_expect(32'h0000_000F, 32'h0000_040F, "period0_no_timeout");
    end
    rd_expect(8'd3, 32'h0000_0000, "rd_period0");

    // read data holds during a board write, unmapped reads as zero, off-board write ignored
    rd_expect(8'd4, Version, "rd_version2");
    reg_addr  = 8'd13;
    reg_wdata = 32'hDEAD_BEEF;
    wr_en     = 1'b1;
    push(1'b0, cyc + 1, Version, 32'hFFFF_FFFF, "rdata_hold_on_write");
    cycle();
    wr_en = 1'b0;
    rd_expect(8'd13, 32'h0000_0000, "rd_unmapped");
    wr(8'h16, 32'h0000_0000);
    pin_expect(32'h0000_0050, 32'h0000_00F0, "offboard_wr_ignored");
    cycles(2);

    drain = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
